// File: rtl/ebus_pi_requester.sv
// ebus_pi_requester: EBUS priority-interrupt requester for one device.
//
// The device posts an interrupt request on int_req. The requester raises its
// PI line at the level assigned by CONO. It answers the PI controller's
// identify cycle with its physical device number. It then delivers the
// device function word in the vector cycle and finally pulses int_ack.
//
// Bit numbering: EBUS bits are named 0..35 with bit 0 the most significant.
// The data buses are declared [35:0], so EBUS bit n lives at index 35-n.
// PI levels 1..7 map onto ebus_pi[6:0] with level 1 at index 6.
//
// Ports:
//   clk, RESET      clock, synchronous active-high reset
//   cono_we         one-cycle CONO strobe; loads cono_pia into the PIA register
//   cono_pia        PI assignment, 0 = disabled
//   int_req         device interrupt request (rising-edge sensitive)
//   vector          device function word, sampled on vector-cycle entry
//   ebus_demand     bus demand from the PI controller
//   ebus_func       EBUS function code (valid with demand)
//   ebus_lvl        PI level being serviced (identify cycles)
//   ebus_data_in    EBUS data in; EBUS bits 7..10 select the device in vector cycles
//   ebus_pi         PI request lines, levels 1..7
//   ebus_xfer       transfer acknowledge
//   ebus_data_out   data driven onto the EBUS
//   ebus_drive      high whenever ebus_data_out is valid
//   int_ack         one-cycle pulse once the vector has been delivered
module ebus_pi_requester #(
  parameter logic [3:0] DEV_NO    = 4'd5,
  parameter logic [2:0] FN_IDENT  = 3'd4,
  parameter logic [2:0] FN_VECTOR = 3'd5,
  parameter logic [7:0] TMO       = 8'd255,
  localparam int unsigned DATA_W  = 36,
  localparam int unsigned PI_W    = 7,
  localparam int unsigned LVL_W   = 3,
  localparam int unsigned TMR_W   = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              cono_we,
  input  logic [LVL_W-1:0]  cono_pia,
  input  logic              int_req,
  input  logic [DATA_W-1:0] vector,
  input  logic              ebus_demand,
  input  logic [2:0]        ebus_func,
  input  logic [LVL_W-1:0]  ebus_lvl,
  input  logic [DATA_W-1:0] ebus_data_in,
  output logic [PI_W-1:0]   ebus_pi,
  output logic              ebus_xfer,
  output logic [DATA_W-1:0] ebus_data_out,
  output logic              ebus_drive,
  output logic              int_ack
);

  // Identify word: a single one at EBUS bit DEV_NO.
  localparam logic [DATA_W-1:0] IDENT_WORD = 36'h8_0000_0000 >> DEV_NO;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_IDENT,
    S_WAIT_FN,
    S_VEC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   pia_q, pia_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               latch_q, latch_d;
  logic               pend_q, pend_d;
  logic               int_req_q;

  logic [PI_W-1:0]    pi_d;
  logic               xfer_d;
  logic               drive_d;
  logic [DATA_W-1:0]  data_d;
  logic               ack_d;

  logic               rise_c;
  logic               in_hs_c;
  logic               ident_hit_c;
  logic               vec_hit_c;
  logic               unused_data;

  // Level 1..7 to a one-hot PI pattern; level 0 requests nothing.
  function automatic logic [PI_W-1:0] lvl_decode(input logic [LVL_W-1:0] lvl);
    logic [PI_W-1:0] v;
    v = '0;
    if (lvl != '0) v = 7'b100_0000 >> (lvl - 3'd1);
    return v;
  endfunction

  assign rise_c      = int_req & ~int_req_q;
  assign in_hs_c     = (state_q == S_IDENT) || (state_q == S_WAIT_FN) || (state_q == S_VEC);
  assign ident_hit_c = ebus_demand && (ebus_func == FN_IDENT) && (ebus_lvl == pia_q);
  // EBUS bits 7..10 sit at indices 28..25.
  assign vec_hit_c   = ebus_demand && (ebus_func == FN_VECTOR) &&
                       (ebus_data_in[28:25] == DEV_NO);
  assign unused_data = ^{ebus_data_in[35:29], ebus_data_in[24:0]};

  // Next-state, request bookkeeping and next output values.
  always_comb begin
    state_d = state_q;
    pia_d   = cono_we ? cono_pia : pia_q;
    lvl_d   = lvl_q;
    timer_d = '0;
    latch_d = latch_q;
    pend_d  = pend_q;
    pi_d    = '0;
    xfer_d  = 1'b0;
    drive_d = 1'b0;
    data_d  = '0;
    ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (latch_q && (pia_q != '0)) state_d = S_REQ;
      end
      S_REQ: begin
        if (pia_q == '0) begin
          state_d = S_IDLE;
        end else if (ident_hit_c) begin
          state_d = S_IDENT;
          lvl_d   = pia_q;
        end
      end
      S_IDENT: begin
        if (!ebus_demand) state_d = S_WAIT_FN;
      end
      S_WAIT_FN: begin
        if (vec_hit_c) begin
          state_d = S_VEC;
        end else if (timer_q == TMO) begin
          state_d = S_REQ;
        end else begin
          timer_d = (timer_q == '1) ? timer_q : timer_q + 8'd1;
        end
      end
      S_VEC: begin
        if (!ebus_demand) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Requests arriving mid-handshake (or on the ack cycle) wait in pend.
    if (state_q == S_DONE) begin
      latch_d = pend_q | rise_c;
      pend_d  = 1'b0;
    end else if (in_hs_c) begin
      pend_d = pend_q | rise_c;
    end else begin
      latch_d = latch_q | rise_c;
    end
    if ((state_d == S_IDLE) && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      latch_d = latch_d | pend_d;
      pend_d  = 1'b0;
    end

    // Outputs follow the next state so they register alongside it.
    case (state_d)
      S_REQ: begin
        pi_d = lvl_decode(pia_d);
      end
      S_IDENT: begin
        pi_d    = lvl_decode(lvl_d);
        xfer_d  = 1'b1;
        drive_d = 1'b1;
        data_d  = IDENT_WORD;
      end
      S_WAIT_FN: begin
        pi_d = lvl_decode(lvl_d);
      end
      S_VEC: begin
        xfer_d  = 1'b1;
        drive_d = 1'b1;
        // Function word is captured once, on entry, and held.
        data_d  = (state_q == S_VEC) ? ebus_data_out : vector;
      end
      S_DONE: begin
        ack_d = 1'b1;
      end
      default: begin
        pi_d = '0;
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      pia_q         <= '0;
      lvl_q         <= '0;
      timer_q       <= '0;
      latch_q       <= 1'b0;
      pend_q        <= 1'b0;
      int_req_q     <= 1'b0;
      ebus_pi       <= '0;
      ebus_xfer     <= 1'b0;
      ebus_drive    <= 1'b0;
      ebus_data_out <= '0;
      int_ack       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pia_q         <= pia_d;
      lvl_q         <= lvl_d;
      timer_q       <= timer_d;
      latch_q       <= latch_d;
      pend_q        <= pend_d;
      int_req_q     <= int_req;
      ebus_pi       <= pi_d;
      ebus_xfer     <= xfer_d;
      ebus_drive    <= drive_d;
      ebus_data_out <= data_d;
      int_ack       <= ack_d;
    end
  end

endmodule

// File: tb/tb_ebus_pi_requester.sv
// Directed bench for ebus_pi_requester: each step pushes the expected output
// bundle, advances one clock and compares the popped entry against the DUT.
module tb_ebus_pi_requester;

  logic        clk = 1'b0;
  logic        RESET;
  logic        cono_we;
  logic [2:0]  cono_pia;
  logic        int_req;
  logic [35:0] vector;
  logic        ebus_demand;
  logic [2:0]  ebus_func;
  logic [2:0]  ebus_lvl;
  logic [35:0] ebus_data_in;
  logic [6:0]  ebus_pi;
  logic        ebus_xfer;
  logic [35:0] ebus_data_out;
  logic        ebus_drive;
  logic        int_ack;

  always #5 clk = ~clk;

  ebus_pi_requester dut (
    .clk           (clk),
    .RESET         (RESET),
    .cono_we       (cono_we),
    .cono_pia      (cono_pia),
    .int_req       (int_req),
    .vector        (vector),
    .ebus_demand   (ebus_demand),
    .ebus_func     (ebus_func),
    .ebus_lvl      (ebus_lvl),
    .ebus_data_in  (ebus_data_in),
    .ebus_pi       (ebus_pi),
    .ebus_xfer     (ebus_xfer),
    .ebus_data_out (ebus_data_out),
    .ebus_drive    (ebus_drive),
    .int_ack       (int_ack)
  );

  localparam logic [6:0]  PI0  = 7'b000_0000;
  localparam logic [6:0]  PI2  = 7'b010_0000;
  localparam logic [6:0]  PI3  = 7'b001_0000;
  localparam logic [35:0] Z    = 36'd0;
  localparam logic [35:0] IDW  = 36'h0_4000_0000;   // EBUS bit 5
  localparam logic [35:0] VSEL = 36'd5 << 25;       // bits 7..10 = 5
  localparam logic [35:0] VBAD = 36'd6 << 25;       // bits 7..10 = 6
  localparam logic [35:0] V1   = 36'o123456000000;
  localparam logic [35:0] V1B  = 36'o000000000777;
  localparam logic [35:0] V2   = 36'o000000765432;
  localparam logic [35:0] V3   = 36'o707070707070;

  typedef struct {
    string       tag;
    logic [45:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // One clock: push expectation, step, pop and compare {pi,xfer,drive,ack,data}.
  task automatic cyc(input string tag, input logic [6:0] pi, input logic x,
                     input logic d, input logic a, input logic [35:0] dat);
    exp_t        e;
    logic [45:0] obs;
    e.tag = tag;
    e.val = {pi, x, d, a, dat};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {ebus_pi, ebus_xfer, ebus_drive, int_ack, ebus_data_out};
    n_vec++;
    assert (obs === e.val) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic quiet(input string tag, input logic [6:0] pi);
    cyc(tag, pi, 1'b0, 1'b0, 1'b0, Z);
  endtask

  task automatic bus(input logic dem, input logic [2:0] fn, input logic [2:0] lvl,
                     input logic [35:0] din);
    ebus_demand  = dem;
    ebus_func    = fn;
    ebus_lvl     = lvl;
    ebus_data_in = din;
  endtask

  initial begin
    RESET = 1'b1; cono_we = 1'b0; cono_pia = 3'd0; int_req = 1'b0; vector = Z;
    bus(1'b0, 3'd0, 3'd0, Z);
    quiet("reset0", PI0);
    quiet("reset1", PI0);
    RESET = 1'b0;

    // Request at level 3.
    cono_we = 1'b1; cono_pia = 3'd3;
    quiet("cono3", PI0);
    cono_we = 1'b0; int_req = 1'b1;
    quiet("req_edge", PI0);
    int_req = 1'b0;
    quiet("pi_up", PI3);
    quiet("req_hold", PI3);
    bus(1'b1, 3'd4, 3'd2, Z);
    quiet("lvl_miss", PI3);
    bus(1'b1, 3'd5, 3'd3, VSEL);
    quiet("fn_miss_req", PI3);

    // Identify.
    bus(1'b1, 3'd4, 3'd3, Z);
    cyc("ident_x", PI3, 1'b1, 1'b1, 1'b0, IDW);
    cyc("ident_hold", PI3, 1'b1, 1'b1, 1'b0, IDW);
    bus(1'b0, 3'd0, 3'd0, Z);
    quiet("ident_drop", PI3);
    quiet("wait1", PI3);

    // Vector with a re-request during VEC.
    vector = V1;
    bus(1'b1, 3'd5, 3'd0, VSEL);
    cyc("vec_x", PI0, 1'b1, 1'b1, 1'b0, V1);
    vector = V1B; int_req = 1'b1;
    cyc("vec_hold", PI0, 1'b1, 1'b1, 1'b0, V1);
    int_req = 1'b0;
    bus(1'b0, 3'd0, 3'd0, Z);
    cyc("done", PI0, 1'b0, 1'b0, 1'b1, Z);
    quiet("idle_after", PI0);
    quiet("rereq", PI3);

    // Timeout back to REQ.
    bus(1'b1, 3'd4, 3'd3, Z);
    cyc("id2", PI3, 1'b1, 1'b1, 1'b0, IDW);
    bus(1'b0, 3'd0, 3'd0, Z);
    quiet("id2_drop", PI3);
    for (int i = 0; i < 300; i++) quiet("tmo_wait", PI3);
    bus(1'b1, 3'd5, 3'd0, VSEL);
    quiet("tmo_novec", PI3);
    bus(1'b0, 3'd0, 3'd0, Z);
    quiet("tmo_req", PI3);

    // Fresh handshake; PIA rewritten mid-handshake keeps the old level.
    bus(1'b1, 3'd4, 3'd3, Z);
    cyc("id3", PI3, 1'b1, 1'b1, 1'b0, IDW);
    bus(1'b0, 3'd0, 3'd0, Z);
    quiet("id3_drop", PI3);
    cono_we = 1'b1; cono_pia = 3'd2;
    quiet("pia_hs", PI3);
    cono_we = 1'b0;
    for (int i = 0; i < 200; i++) quiet("w200", PI3);
    bus(1'b1, 3'd5, 3'd0, VBAD);
    quiet("sel_miss", PI3);
    vector = V2;
    bus(1'b1, 3'd5, 3'd0, VSEL);
    cyc("vec2", PI0, 1'b1, 1'b1, 1'b0, V2);
    bus(1'b0, 3'd0, 3'd0, Z);
    cyc("done2", PI0, 1'b0, 1'b0, 1'b1, Z);
    quiet("idle2", PI0);
    quiet("idle2b", PI0);

    // New level applies; disable and re-enable.
    int_req = 1'b1;
    quiet("r3_edge", PI0);
    int_req = 1'b0;
    quiet("r3_pi", PI2);
    bus(1'b1, 3'd4, 3'd3, Z);
    quiet("lvl3_miss", PI2);
    bus(1'b0, 3'd0, 3'd0, Z);
    cono_we = 1'b1; cono_pia = 3'd0;
    quiet("pia0", PI0);
    cono_we = 1'b0;
    quiet("dis1", PI0);
    quiet("dis2", PI0);
    cono_we = 1'b1; cono_pia = 3'd3;
    quiet("pia3", PI0);
    cono_we = 1'b0;
    quiet("reassert", PI3);

    // Reset mid-identify.
    bus(1'b1, 3'd4, 3'd3, Z);
    cyc("id4", PI3, 1'b1, 1'b1, 1'b0, IDW);
    RESET = 1'b1;
    quiet("rst_mid", PI0);
    RESET = 1'b0;
    bus(1'b0, 3'd0, 3'd0, Z);
    quiet("post_rst", PI0);
    int_req = 1'b1;
    quiet("rst_req", PI0);
    int_req = 1'b0;
    quiet("rst_pia0", PI0);
    cono_we = 1'b1; cono_pia = 3'd3;
    quiet("pia3b", PI0);
    cono_we = 1'b0;
    quiet("rq5", PI3);

    // Request arriving on the ack cycle.
    bus(1'b1, 3'd4, 3'd3, Z);
    cyc("id5", PI3, 1'b1, 1'b1, 1'b0, IDW);
    bus(1'b0, 3'd0, 3'd0, Z);
    quiet("id5_drop", PI3);
    vector = V3;
    bus(1'b1, 3'd5, 3'd0, VSEL);
    cyc("vec3", PI0, 1'b1, 1'b1, 1'b0, V3);
    bus(1'b0, 3'd0, 3'd0, Z);
    cyc("done3", PI0, 1'b0, 1'b0, 1'b1, Z);
    int_req = 1'b1;
    quiet("idle3", PI0);
    int_req = 1'b0;
    quiet("rereq3", PI3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ebus_pi_requester.md
EBUS_PI_REQUESTER -- requirements
Module: ebus_pi_requester

Interface
Parameters:
REQ-001 DEV_NO, 4'd5, physical device number (0-15) returned in identify cycles.
REQ-002 FN_IDENT, 3'd4, EBUS function code for the PI identify cycle.
REQ-003 FN_VECTOR, 3'd5, EBUS function code for the PI function-word read cycle.
REQ-004 TMO, 8'd255, cycles to wait in WAIT_FN before abandoning service.
Ports:
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 cono_we  in  1  one-cycle CONO strobe for this device.
REQ-008 cono_pia  in  3  PI assignment loaded on cono_we; 0 = disabled.
REQ-009 int_req  in  1  device interrupt request pulse, one or more cycles wide.
REQ-010 vector  in  36  interrupt function word supplied by the device.
REQ-011 ebus_demand  in  1  bus demand from the PI controller.
REQ-012 ebus_func  in  3  EBUS function code, valid while ebus_demand is high.
REQ-013 ebus_lvl  in  3  PI level being serviced, valid in identify cycles.
REQ-014 ebus_data_in  in  36  EBUS data, bits 0..35; bits 7..10 carry the selected physical number in vector cycles.
REQ-015 ebus_pi  out  7  PI request lines, levels 1..7.
REQ-016 ebus_xfer  out  1  transfer acknowledge.
REQ-017 ebus_data_out  out  36  data driven onto the EBUS.
REQ-018 ebus_drive  out  1  high whenever ebus_data_out is valid.
REQ-019 int_ack  out  1  one-cycle pulse when the vector has been delivered.

Function
REQ-020 PIA register: loads cono_pia on cono_we; holds its value otherwise.
REQ-021 Request latch: set by a rising edge of int_req; cleared when int_ack pulses.
REQ-022 Re-request: a rising edge of int_req while in IDENT, WAIT_FN or VEC sets a pending flag; on return to IDLE the pending flag moves into the latch.
REQ-023 States: IDLE, REQ, IDENT, WAIT_FN, VEC, DONE.
REQ-024 IDLE -> REQ when the latch is set and PIA != 0.
REQ-025 REQ: ebus_pi[PIA] is high; all other pi bits are low.
REQ-026 REQ -> IDLE if PIA becomes 0; the latch is kept.
REQ-027 REQ -> IDENT when ebus_demand=1, ebus_func=FN_IDENT and ebus_lvl=PIA.
REQ-028 IDENT: ebus_pi line stays high.
REQ-029 IDENT drives: ebus_xfer=1, ebus_drive=1, ebus_data_out[DEV_NO]=1, all other bits 0.
REQ-030 IDENT -> WAIT_FN on the first cycle with ebus_demand=0; xfer therefore drops one cycle after demand falls.
REQ-031 WAIT_FN: ebus_pi line stays high; an 8-bit timer counts up from 0.
REQ-032 WAIT_FN -> VEC when ebus_demand=1, ebus_func=FN_VECTOR and ebus_data_in[7:10]=DEV_NO.
REQ-033 WAIT_FN -> REQ when the timer reaches TMO; the timer saturates and does not wrap.
REQ-034 VEC: ebus_pi is low.
REQ-035 VEC drives: ebus_xfer=1, ebus_drive=1, ebus_data_out=vector registered on VEC entry.
REQ-036 VEC -> DONE when ebus_demand falls.
REQ-037 DONE: int_ack=1 for exactly one cycle; the latch clears; DONE -> IDLE.
REQ-038 Outside IDENT and VEC: ebus_xfer=0, ebus_drive=0, ebus_data_out=0.
REQ-039 Latency: xfer rises on the cycle after the qualifying demand is sampled.
REQ-040 A demand whose func or level does not match is ignored in every state.
REQ-041 PIA write during IDENT, WAIT_FN or VEC: the handshake in progress completes under the old level, and the new PIA applies from IDLE.
REQ-042 int_req asserted on the same cycle as DONE: the request is captured as pending and is not lost.

Reset
REQ-043 When RESET=1, on the next edge: state=IDLE; PIA=0; latch, pending flag and timer are 0; all outputs are 0.
REQ-044 RESET asserted mid-handshake drops xfer and the pi line on the next edge.

Verification
REQ-045 Scenario 1: CONO PIA=3, int_req pulse -> ebus_pi=7'b0010000 two cycles later.
REQ-046 Scenario 2 (identify): demand with func=4, lvl=3 -> xfer and data bit 5 set the next cycle; both drop one cycle after demand falls.
REQ-047 Scenario 3 (vector): demand with func=5, data[7:10]=5, vector=36'o123456000000 -> data_out=36'o123456000000, then one-cycle int_ack, ebus_pi=0.
REQ-048 Scenario 4 (timeout): identify completes, no vector read for 255 cycles -> back to REQ with pi level 3 still high.
REQ-049 Scenario 5 (mismatch and disable): identify on lvl=2 -> no xfer; PIA set to 0 while in REQ -> pi drops, state IDLE; PIA set back to 3 -> request reasserts.
REQ-050 Scenario 6 (edges): int_req during VEC -> a second request cycle follows DONE; RESET during IDENT -> all outputs 0 on the next edge.
